// File: rtl/if_id_skid.sv
// IF/ID pipeline stage: carries PC+4 and instruction from fetch to decode through a
// two-entry skid buffer with valid/ready on both sides and a synchronous flush.
module if_id_skid #(
    parameter int                 PC_W    = 32,
    parameter int                 INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP     = {INSTR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc4,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc4,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_main_pc4;
    logic [PC_W-1:0]    r_skid_pc4;
    logic [PC_W-1:0]    w_main_pc4_nxt;
    logic [PC_W-1:0]    w_skid_pc4_nxt;
    logic [INSTR_W-1:0] r_main_instr;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [INSTR_W-1:0] w_main_instr_nxt;
    logic [INSTR_W-1:0] w_skid_instr_nxt;
    logic               w_accept;
    logic               w_take;

    // in_ready decodes only the state register, so out_ready never reaches it combinationally.
    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign occupancy = r_state;
    assign out_pc4   = r_main_pc4;
    assign out_instr = r_main_instr;

    assign w_accept = in_valid & in_ready;
    assign w_take   = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_pc4_nxt   = r_main_pc4;
        w_main_instr_nxt = r_main_instr;
        w_skid_pc4_nxt   = r_skid_pc4;
        w_skid_instr_nxt = r_skid_instr;

        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt      = HALF;
                    w_main_pc4_nxt   = in_pc4;
                    w_main_instr_nxt = in_instr;
                end
            end
            HALF: begin
                if (w_accept && w_take) begin
                    w_main_pc4_nxt   = in_pc4;
                    w_main_instr_nxt = in_instr;
                end else if (w_accept) begin
                    w_state_nxt      = FULL;
                    w_skid_pc4_nxt   = in_pc4;
                    w_skid_instr_nxt = in_instr;
                end else if (w_take) begin
                    w_state_nxt      = EMPTY;
                    w_main_pc4_nxt   = '0;
                    w_main_instr_nxt = NOP;
                end
            end
            FULL: begin
                if (w_take) begin
                    w_state_nxt      = HALF;
                    w_main_pc4_nxt   = r_skid_pc4;
                    w_main_instr_nxt = r_skid_instr;
                end
            end
            default: begin
                w_state_nxt      = EMPTY;
                w_main_pc4_nxt   = '0;
                w_main_instr_nxt = NOP;
            end
        endcase

        // A squash overrides every move above, including an accept at the same edge.
        if (flush) begin
            w_state_nxt      = EMPTY;
            w_main_pc4_nxt   = '0;
            w_main_instr_nxt = NOP;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_main_pc4   <= '0;
            r_main_instr <= NOP;
            r_skid_pc4   <= '0;
            r_skid_instr <= NOP;
        end else begin
            r_state      <= w_state_nxt;
            r_main_pc4   <= w_main_pc4_nxt;
            r_main_instr <= w_main_instr_nxt;
            r_skid_pc4   <= w_skid_pc4_nxt;
            r_skid_instr <= w_skid_instr_nxt;
        end
    end

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed and random traffic checked through a queue-based
// scoreboard, plus a 16-bit instance with a non-zero NOP.
module tb_if_id_skid;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc4;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc4;
    logic [31:0] out_instr;
    logic [1:0]  occupancy;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_in_pc4;
    logic [15:0] s_in_instr;
    logic        s_flush;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_out_pc4;
    logic [15:0] s_out_instr;
    logic [1:0]  s_occupancy;

    entry_t sbq[$];
    int     total;
    int     bad;

    if_id_skid u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc4    (in_pc4),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc4   (out_pc4),
        .out_instr (out_instr),
        .occupancy (occupancy)
    );

    if_id_skid #(
        .PC_W    (16),
        .INSTR_W (16),
        .NOP     (16'hFFFF)
    ) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_pc4    (s_in_pc4),
        .in_instr  (s_in_instr),
        .flush     (s_flush),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_pc4   (s_out_pc4),
        .out_instr (s_out_instr),
        .occupancy (s_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of fetch/decode activity; the accepted entry enters the model just after the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                 input logic ordy, input logic fl);
        bit     acc;
        entry_t e;
        @(posedge clk);
        in_valid  = v;
        in_pc4    = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        acc       = v && (sbq.size() < 2) && !fl;
        e.pc4     = pc;
        e.instr   = ins;
        @(negedge clk);
        #1;
        if (acc) sbq.push_back(e);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, ordy, 1'b0);
    endtask

    // Monitor: compares DUT status and head entry against the model, then retires takes/flushes.
    initial begin
        bit take;
        bit fl;
        forever begin
            @(posedge clk);
            #2;
            take = 1'b0;
            fl   = 1'b0;
            if (rst_n) begin
                checkOutput("occupancy", {30'd0, occupancy}, sbq.size());
                checkOutput("in_ready", {31'd0, in_ready}, {31'd0, sbq.size() < 2});
                checkOutput("out_valid", {31'd0, out_valid}, {31'd0, sbq.size() > 0});
                if (sbq.size() > 0) begin
                    checkOutput("out_pc4", out_pc4, sbq[0].pc4);
                    checkOutput("out_instr", out_instr, sbq[0].instr);
                end else begin
                    checkOutput("empty_pc4", out_pc4, 32'h0);
                    checkOutput("empty_instr", out_instr, 32'h0);
                end
                take = out_ready && (sbq.size() > 0);
                fl   = flush;
            end
            @(negedge clk);
            if (rst_n) begin
                if (take) void'(sbq.pop_front());
                if (fl) sbq.delete();
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_pc4      = '0;
        in_instr    = '0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        s_in_valid  = 1'b0;
        s_in_pc4    = '0;
        s_in_instr  = '0;
        s_out_ready = 1'b0;
        s_flush     = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst16_out_instr", {16'd0, s_out_instr}, 32'h0000FFFF);
        checkOutput("rst16_out_pc4", {16'd0, s_out_pc4}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming at full rate.
        applyStimulus(1'b1, 32'h4, 32'h20080001, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h20090002, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hC, 32'h012A5020, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Decode stall fills the skid, then drains in order.
        applyStimulus(1'b1, 32'h4, 32'h11111111, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h22222222, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 32'h33333333, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Flush from FULL with a concurrent input, then from HALF with a concurrent input.
        applyStimulus(1'b1, 32'h4, 32'hAAAA0004, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'hAAAA0008, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 32'hAAAA000C, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h10, 32'hBBBB0010, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h14, 32'hBBBB0014, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Simultaneous accept and take in HALF.
        applyStimulus(1'b1, 32'h4, 32'hCCCC0004, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'hCCCC0008, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Asynchronous reset while FULL.
        applyStimulus(1'b1, 32'h40, 32'hDDDD0040, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h44, 32'hDDDD0044, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_out_instr", out_instr, 32'h0);
        checkOutput("midrst_out_pc4", out_pc4, 32'h0);
        checkOutput("midrst_occupancy", {30'd0, occupancy}, 32'd0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 16-bit instance: one entry in, then flushed back to its NOP.
        @(posedge clk);
        #2;
        s_in_valid = 1'b1;
        s_in_pc4   = 16'h1234;
        s_in_instr = 16'hABCD;
        @(posedge clk);
        #2;
        s_in_valid = 1'b0;
        checkOutput("w16_out_valid", {31'd0, s_out_valid}, 32'd1);
        checkOutput("w16_out_instr", {16'd0, s_out_instr}, 32'h0000ABCD);
        checkOutput("w16_out_pc4", {16'd0, s_out_pc4}, 32'h00001234);
        s_flush = 1'b1;
        @(posedge clk);
        #2;
        s_flush = 1'b0;
        checkOutput("w16_flush_valid", {31'd0, s_out_valid}, 32'd0);
        checkOutput("w16_flush_instr", {16'd0, s_out_instr}, 32'h0000FFFF);
        checkOutput("w16_flush_pc4", {16'd0, s_out_pc4}, 32'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), $urandom(), $urandom(),
                          ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
        end
        idle(4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_skid.md
# if_id_skid

Parametrised IF/ID pipeline stage carrying the PC+4 and instruction words from fetch to decode, with a valid/ready handshake on both sides. Fixes the fixed-width, bubble-as-high-Z stage: valid bit, synchronous flush for branch/jump squash, and a 2-entry skid buffer. The stage absorbs a decode stall without a combinational path from `out_ready` back to `in_ready`. Sits between the PC/instruction-memory fetch logic and the decode/register-file stage.

## Interface
- `PC_W`, 32: width of PC+4 field.
- `INSTR_W`, 32: width of instruction field.
- `NOP`, `{INSTR_W{1'b0}}`: instruction value presented when the stage holds no valid entry.

Ports:
- `clk`  in  1  clock; all state updates on the falling edge of `clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents a valid PC+4/instruction pair.
- `in_ready`  out  1  stage can accept this cycle.
- `in_pc4`  in  PC_W  PC+4 from fetch.
- `in_instr`  in  INSTR_W  instruction from memory.
- `flush`  in  1  synchronous squash of all held entries.
- `out_valid`  out  1  `out_pc4`/`out_instr` hold a valid entry.
- `out_ready`  in  1  decode consumes the entry this cycle.
- `out_pc4`  out  PC_W  PC+4 to decode.
- `out_instr`  out  INSTR_W  instruction to decode.
- `occupancy`  out  2  entries held, 0..2.

## Operation
- Storage: main register (drives outputs) and skid register, each with data fields. Combined occupancy is tracked as state EMPTY (0), HALF (1), or FULL (2).
- `accept = in_valid & in_ready`; `take = out_valid & out_ready`.
- `in_ready = (state != FULL)`. It is a decode of the state register only, with no dependence on `out_ready` or `in_valid`.
- `out_valid = (state != EMPTY)`; `occupancy` = state encoding 0/1/2.
- Transitions and data moves:
  - EMPTY: `accept` -> HALF, main <= in.
  - HALF:
    - `accept & take` -> HALF, main <= in.
    - `accept & !take` -> FULL, skid <= in; main unchanged.
    - `!accept & take` -> EMPTY.
    - Otherwise hold.
  - FULL: `take` -> HALF, main <= skid. Otherwise hold. No accept is possible.
- Ordering: entries leave in arrival order. The skid entry is always younger than the main entry.
- Output data when `out_valid=0`: `out_instr = NOP`, `out_pc4 = 0`. The outputs are never X or Z. Main data is forced to these values whenever the state becomes EMPTY.
- `flush` has top priority. At the edge where `flush=1`, the state becomes EMPTY and main becomes NOP/0. An input accepted at that same edge is discarded, and a take at that edge is still considered consumed by decode.
- Data registers do not change except on the moves listed above. A stalled entry is held bit-exact.

## Timing
- Reset (`rst_n=0`, asynchronous): state EMPTY, `in_ready=1`, `out_valid=0`, `out_pc4=0`, `out_instr=NOP`, `occupancy=0`. Reset may assert mid-transfer; all held entries are lost with no partial output.
- Release of `rst_n` is synchronised externally. The first accept is possible at the first falling edge after release.
- Latency: an entry accepted at falling edge N appears with `out_valid=1` immediately after edge N (1-cycle register latency).
- Throughput: 1 entry/cycle sustained while `out_ready=1`.
- Stall: with `out_ready=0`, the stage accepts at most 2 entries, then `in_ready=0` from just after the second accept.
- Restart: in FULL, the first `take` frees one slot. `in_ready=1` after that edge, so one accept is possible per cycle thereafter.
- `flush`: after the flush edge, `out_valid=0` and `in_ready=1`. A fresh accept is possible at the very next edge.
- All outputs are registered or a pure decode of registers.

## Test plan
- Reset: drive `rst_n=0` mid-stream with occupancy 2 -> immediately `out_valid=0`, `in_ready=1`, `out_instr=NOP`, `out_pc4=0`, `occupancy=0`.
- Streaming: `out_ready=1`, feed pc4 0x4,0x8,0xC with instrs 0x20080001,0x20090002,0x012A5020 on consecutive edges -> same values appear in order one edge later, `occupancy` stays 1, no gaps.
- Stall/skid: `out_ready=0`, feed 0x4 then 0x8 -> `occupancy=2`, `in_ready=0`, out holds pc4=0x4. Next, `out_ready=1` for 2 cycles -> 0x4 then 0x8 emitted, `in_ready=1` after the first take.
- Flush priority: state FULL (0x4, 0x8), assert `flush` with `in_valid=1`, pc4=0xC, at the same edge -> `out_valid=0`, `occupancy=0`, `out_instr=NOP`, and 0xC never appears.
- Simultaneous accept/take in HALF: main=0x4, `in_valid=1` with 0x8, `out_ready=1` -> `occupancy` stays 1, out becomes 0x8.
- Parameter sweep: `PC_W=16`, `INSTR_W=16`, `NOP=16'hFFFF` -> empty output `out_instr=0xFFFF`. Random valid/ready/flush traffic against a queue model shows no loss, duplication, or reordering.
